// File: rtl/value_display_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// value_display_ctrl_pkg
// Shared definitions for the value display sequencer:
//   - ASCII constants used when building the four display characters
//   - top-level sequencer state enum
//   - phase enum of the digit extraction unit
//   - digit_char(): converts a 0..9 digit into its ASCII code
// ---------------------------------------------------------------------------
package value_display_ctrl_pkg;

   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_PLUS  = 8'h2B;
   localparam logic [7:0] CH_MINUS = 8'h2D;
   localparam logic [7:0] CH_ZERO  = 8'h30;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SUB100 = 3'd2,
      ST_SUB10  = 3'd3,
      ST_FORMAT = 3'd4,
      ST_EMIT   = 3'd5,
      ST_DONE   = 3'd6
   } state_t;

   typedef enum logic [1:0] {
      DX_IDLE   = 2'd0,
      DX_LOAD   = 2'd1,
      DX_SUB100 = 2'd2,
      DX_SUB10  = 2'd3
   } dx_phase_t;

   function automatic logic [7:0] digit_char(input logic [3:0] d);
      return CH_ZERO + {4'b0000, d};
   endfunction

endpackage

// File: rtl/value_display_ctrl_if.sv
// ---------------------------------------------------------------------------
// value_display_ctrl_if
// Character write bus between the sequencer and the display character sink.
//   char_we    : write valid (master -> slave)
//   char_addr  : character address, ADDR_W bits (master -> slave)
//   char_data  : ASCII character (master -> slave)
//   char_ready : sink ready; a transfer happens when char_we && char_ready
// ---------------------------------------------------------------------------
interface value_display_ctrl_if #(
   parameter int ADDR_W = 5
) ();

   logic              char_we;
   logic [ADDR_W-1:0] char_addr;
   logic [7:0]        char_data;
   logic              char_ready;

   modport master (
      output char_we,
      output char_addr,
      output char_data,
      input  char_ready
   );

   modport slave (
      input  char_we,
      input  char_addr,
      input  char_data,
      output char_ready
   );

endinterface

// File: rtl/value_display_ctrl_dec_digit_extract.sv
// ---------------------------------------------------------------------------
// dec_digit_extract
// Iterative subtract-and-count conversion of a signed 8-bit value into the
// decimal digits of its magnitude (0..128).
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   i_start          : start pulse, accepted only while o_ready is high
//   i_value          : two's-complement value, sampled on accepted start
//   o_ready          : unit idle, can accept i_start
//   o_advance        : combinational, high in the last cycle of the hundreds
//                      phase and in the last cycle of the tens phase
//   o_h, o_t, o_o    : hundreds, tens and ones digits
//   o_digits_valid   : one-cycle pulse when o_h/o_t/o_o are final
// ---------------------------------------------------------------------------
module dec_digit_extract
   import value_display_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_start,
   input  logic signed [7:0] i_value,
   output logic              o_ready,
   output logic              o_advance,
   output logic [3:0]        o_h,
   output logic [3:0]        o_t,
   output logic [3:0]        o_o,
   output logic              o_digits_valid
);

   dx_phase_t         r_phase;
   logic signed [7:0] r_value;
   logic [7:0]        r_rem;
   logic [3:0]        r_h;
   logic [3:0]        r_t;
   logic [3:0]        r_o;
   logic              r_digits_valid;
   logic [7:0]        w_mag;

   // -128 negates to 8'h80, which read as unsigned is the required 128
   assign w_mag = r_value[7] ? (~$unsigned(r_value) + 8'd1) : $unsigned(r_value);

   // Lets the parent FSM follow the phase changes on the same edge
   assign o_advance = ((r_phase == DX_SUB100) && (r_rem < 8'd100)) ||
                      ((r_phase == DX_SUB10)  && (r_rem < 8'd10));

   assign o_ready        = (r_phase == DX_IDLE);
   assign o_h            = r_h;
   assign o_t            = r_t;
   assign o_o            = r_o;
   assign o_digits_valid = r_digits_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_phase        <= DX_IDLE;
         r_value        <= '0;
         r_rem          <= '0;
         r_h            <= '0;
         r_t            <= '0;
         r_o            <= '0;
         r_digits_valid <= 1'b0;
      end else begin
         r_digits_valid <= 1'b0;
         case (r_phase)
            DX_IDLE: begin
               if (i_start) begin
                  r_value <= i_value;
                  r_phase <= DX_LOAD;
               end
            end
            DX_LOAD: begin
               r_rem   <= w_mag;
               r_h     <= '0;
               r_t     <= '0;
               r_phase <= DX_SUB100;
            end
            DX_SUB100: begin
               if (r_rem >= 8'd100) begin
                  r_rem <= r_rem - 8'd100;
                  r_h   <= r_h + 4'd1;
               end else begin
                  r_phase <= DX_SUB10;
               end
            end
            DX_SUB10: begin
               if (r_rem >= 8'd10) begin
                  r_rem <= r_rem - 8'd10;
                  r_t   <= r_t + 4'd1;
               end else begin
                  // remainder is below 10 here, so the low nibble is the ones digit
                  r_o            <= r_rem[3:0];
                  r_digits_valid <= 1'b1;
                  r_phase        <= DX_IDLE;
               end
            end
            default: r_phase <= DX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/value_display_ctrl.sv
// ---------------------------------------------------------------------------
// value_display_ctrl
// Converts a signed 8-bit CPU value into four ASCII characters (sign or '0',
// then left-justified decimal digits padded with spaces) and writes them to
// consecutive display addresses through a valid/ready character bus.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   i_start    : request pulse, accepted only in IDLE
//   i_value    : two's-complement value, sampled on accepted start
//   i_pos      : address of the first character, sampled on accepted start
//   o_busy     : high from the cycle after an accepted start through DONE
//   o_done     : one-cycle pulse after the fourth character transfer
//   char_bus   : character write bus (master side)
// ---------------------------------------------------------------------------
module value_display_ctrl
   import value_display_ctrl_pkg::*;
#(
   parameter int ADDR_W = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_start,
   input  logic signed [7:0]    i_value,
   input  logic [ADDR_W-1:0]    i_pos,
   output logic                 o_busy,
   output logic                 o_done,
   value_display_ctrl_if.master char_bus
);

   state_t            r_state;
   logic              r_neg;
   logic [ADDR_W-1:0] r_pos;
   logic [1:0]        r_idx;
   logic [3:0][7:0]   r_chars;
   logic              r_char_we;
   logic [ADDR_W-1:0] r_char_addr;
   logic [7:0]        r_char_data;
   logic              r_busy;
   logic              r_done;

   logic              w_dx_start;
   logic              w_dx_ready;
   logic              w_dx_advance;
   logic [3:0]        w_h;
   logic [3:0]        w_t;
   logic [3:0]        w_o;
   logic              w_digits_valid;
   logic [3:0][7:0]   w_chars;

   // c0 is the sign ('0' for a zero value), c1..c3 the digits left-justified
   function automatic logic [3:0][7:0] format_chars(
      input logic       neg,
      input logic [3:0] h,
      input logic [3:0] t,
      input logic [3:0] o
   );
      logic [3:0][7:0] c;
      c    = {4{CH_SPACE}};
      c[0] = neg ? CH_MINUS : CH_PLUS;
      if (h != 4'd0) begin
         c[1] = digit_char(h);
         c[2] = digit_char(t);
         c[3] = digit_char(o);
      end else if (t != 4'd0) begin
         c[1] = digit_char(t);
         c[2] = digit_char(o);
      end else if (o != 4'd0) begin
         c[1] = digit_char(o);
      end else begin
         c[0] = CH_ZERO;
      end
      return c;
   endfunction

   assign w_dx_start = (r_state == ST_IDLE) && i_start && w_dx_ready;
   assign w_chars    = format_chars(r_neg, w_h, w_t, w_o);

   dec_digit_extract u_dec_digit_extract (
      .clk            (clk),
      .reset          (reset),
      .i_start        (w_dx_start),
      .i_value        (i_value),
      .o_ready        (w_dx_ready),
      .o_advance      (w_dx_advance),
      .o_h            (w_h),
      .o_t            (w_t),
      .o_o            (w_o),
      .o_digits_valid (w_digits_valid)
   );

   assign char_bus.char_we   = r_char_we;
   assign char_bus.char_addr = r_char_addr;
   assign char_bus.char_data = r_char_data;
   assign o_busy             = r_busy;
   assign o_done             = r_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_neg       <= 1'b0;
         r_pos       <= '0;
         r_idx       <= '0;
         r_chars     <= {4{CH_SPACE}};
         r_char_we   <= 1'b0;
         r_char_addr <= '0;
         r_char_data <= CH_SPACE;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (w_dx_start) begin
                  r_neg   <= i_value[7];
                  r_pos   <= i_pos;
                  r_busy  <= 1'b1;
                  r_state <= ST_LOAD;
               end
            end
            // The three conversion states track the extraction unit phase by phase
            ST_LOAD:   r_state <= ST_SUB100;
            ST_SUB100: if (w_dx_advance) r_state <= ST_SUB10;
            ST_SUB10:  if (w_dx_advance) r_state <= ST_FORMAT;
            ST_FORMAT: begin
               if (w_digits_valid) begin
                  r_chars     <= w_chars;
                  r_char_we   <= 1'b1;
                  r_char_addr <= r_pos;
                  r_char_data <= w_chars[0];
                  r_idx       <= 2'd0;
                  r_state     <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               // Without a transfer everything holds, so the sink sees stable data
               if (r_char_we && char_bus.char_ready) begin
                  if (r_idx == 2'd3) begin
                     r_char_we <= 1'b0;
                     r_done    <= 1'b1;
                     r_state   <= ST_DONE;
                  end else begin
                     r_idx       <= r_idx + 2'd1;
                     r_char_addr <= r_char_addr + ADDR_W'(1);
                     r_char_data <= r_chars[r_idx + 2'd1];
                  end
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_value_display_ctrl.sv
// ---------------------------------------------------------------------------
// tb_value_display_ctrl
// Self-checking bench: expected character writes are queued when a start is
// issued and compared as the DUT transfers them; per-scenario tasks check
// latency, busy/done and handshake hold behaviour.
// ---------------------------------------------------------------------------
module tb_value_display_ctrl;

   localparam int ADDR_W = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic              i_start;
   logic signed [7:0] i_value;
   logic [ADDR_W-1:0] i_pos;
   logic              o_busy;
   logic              o_done;

   value_display_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   value_display_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .i_start  (i_start),
      .i_value  (i_value),
      .i_pos    (i_pos),
      .o_busy   (o_busy),
      .o_done   (o_done),
      .char_bus (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int xfers  = 0;
   logic [ADDR_W+7:0] sb_q[$];

   // Scoreboard monitor: every transfer is popped against the queued model
   always @(negedge clk) begin
      if (reset === 1'b0 && bus.char_we === 1'b1 && bus.char_ready === 1'b1) begin
         logic [ADDR_W+7:0] exp;
         xfers++;
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL char_write_extra: got addr=%0d data=%h, required no write",
                     bus.char_addr, bus.char_data);
         end else begin
            exp = sb_q.pop_front();
            if ({bus.char_addr, bus.char_data} !== exp) begin
               errors++;
               $display("FAIL char_write: got addr=%0d data=%h, required addr=%0d data=%h",
                        bus.char_addr, bus.char_data, exp[ADDR_W+7:8], exp[7:0]);
            end
         end
      end
   end

   task automatic push_model(input logic [7:0] v, input logic [ADDR_W-1:0] p);
      int sv;
      int m;
      logic [7:0] c[4];
      sv = int'($signed(v));
      m  = (sv < 0) ? -sv : sv;
      c[0] = (sv < 0) ? 8'h2D : 8'h2B;
      c[1] = 8'h20; c[2] = 8'h20; c[3] = 8'h20;
      if (m == 0) begin
         c[0] = 8'h30;
      end else if (m >= 100) begin
         c[1] = 8'h30 + 8'(m / 100);
         c[2] = 8'h30 + 8'((m / 10) % 10);
         c[3] = 8'h30 + 8'(m % 10);
      end else if (m >= 10) begin
         c[1] = 8'h30 + 8'(m / 10);
         c[2] = 8'h30 + 8'(m % 10);
      end else begin
         c[1] = 8'h30 + 8'(m);
      end
      for (int i = 0; i < 4; i++) sb_q.push_back({p + ADDR_W'(i), c[i]});
   endtask

   function automatic int model_latency(input logic [7:0] v);
      int sv;
      int m;
      sv = int'($signed(v));
      m  = (sv < 0) ? -sv : sv;
      return 1 + (m / 100 + 1) + ((m / 10) % 10 + 1) + 1 + 4 + 1;
   endfunction

   // Start is sampled by the edge inside this task; returns 1 ns after it
   task automatic do_start(input logic [7:0] v, input logic [ADDR_W-1:0] p);
      i_value = v;
      i_pos   = p;
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
   endtask

   // cyc counts edges from the start edge (inclusive) until done is seen
   task automatic wait_done(output int cyc);
      cyc = 1;
      while (o_done !== 1'b1 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      i_start = 1'b0;
      i_value = '0;
      i_pos = '0;
      bus.char_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", o_busy); end
      checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", o_done); end
      checks++; if (bus.char_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b, required 0", bus.char_we); end
      checks++; if (bus.char_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d, required 0", bus.char_addr); end
      checks++; if (bus.char_data !== 8'h20) begin errors++; $display("FAIL reset_data: got %h, required 20", bus.char_data); end
      reset = 1'b0;
      idle_cycles(2);
   endtask

   task automatic test_string(input logic [7:0] v, input logic [ADDR_W-1:0] p);
      int cyc;
      int x0;
      push_model(v, p);
      x0 = xfers;
      do_start(v, p);
      checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL busy_rise v=%h: got %b, required 1", v, o_busy); end
      wait_done(cyc);
      checks++; if (cyc !== model_latency(v)) begin errors++; $display("FAIL latency v=%h: got %0d, required %0d", v, cyc, model_latency(v)); end
      checks++; if (bus.char_we !== 1'b0 || o_busy !== 1'b1) begin errors++; $display("FAIL done_cycle v=%h: got we=%b busy=%b, required we=0 busy=1", v, bus.char_we, o_busy); end
      @(posedge clk); #1;
      checks++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin errors++; $display("FAIL after_done v=%h: got busy=%b done=%b, required 0 0", v, o_busy, o_done); end
      checks++; if (xfers - x0 !== 4 || sb_q.size() != 0) begin errors++; $display("FAIL xfer_count v=%h: got %0d left=%0d, required 4 left=0", v, xfers - x0, sb_q.size()); end
      idle_cycles(2);
   endtask

   task automatic test_zero();
      test_string(8'h00, 5'd3);
   endtask

   task automatic test_extremes();
      test_string(8'h7F, 5'd0);
      test_string(8'h80, 5'd0);
   endtask

   task automatic test_wrap();
      test_string(8'hF6, 5'd30);
   endtask

   task automatic test_stall();
      int n;
      int cyc;
      int x0;
      logic [ADDR_W-1:0] a1;
      a1 = 5'd7 + 5'd1;
      push_model(8'h2A, 5'd7);
      x0 = xfers;
      do_start(8'h2A, 5'd7);
      n = 0;
      while (!(bus.char_we === 1'b1 && bus.char_addr === a1) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      bus.char_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (bus.char_we !== 1'b1 || bus.char_addr !== a1 || bus.char_data !== 8'h34) begin
            errors++;
            $display("FAIL stall_hold k=%0d: got we=%b addr=%0d data=%h, required we=1 addr=%0d data=34",
                     k, bus.char_we, bus.char_addr, bus.char_data, a1);
         end
         @(posedge clk); #1;
      end
      bus.char_ready = 1'b1;
      wait_done(cyc);
      checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b, required 1", o_done); end
      checks++; if (xfers - x0 !== 4 || sb_q.size() != 0) begin errors++; $display("FAIL stall_xfers: got %0d left=%0d, required 4 left=0", xfers - x0, sb_q.size()); end
      idle_cycles(2);
   endtask

   task automatic test_ignore_start();
      int cyc;
      int x0;
      int falls;
      logic prev_busy;
      push_model(8'h2A, 5'd10);
      x0 = xfers;
      do_start(8'h2A, 5'd10);
      // now 1 cycle after start; SUB10 spans cycles 3..7 for 42
      repeat (3) @(posedge clk);
      #1;
      do_start(8'h63, 5'd20);
      wait_done(cyc);
      checks++; if (cyc + 4 !== model_latency(8'h2A)) begin errors++; $display("FAIL ignore_latency: got %0d, required %0d", cyc + 4, model_latency(8'h2A)); end
      do_start(8'h63, 5'd20);
      falls = 1;
      prev_busy = o_busy;
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL ignore_busy_fall: got %b, required 0", o_busy); end
      for (int k = 0; k < 15; k++) begin
         @(posedge clk); #1;
         if (prev_busy === 1'b1 && o_busy === 1'b0) falls++;
         if (o_busy === 1'b1) falls += 10;
         prev_busy = o_busy;
      end
      checks++; if (falls !== 1) begin errors++; $display("FAIL ignore_busy_once: got score %0d, required 1", falls); end
      checks++; if (xfers - x0 !== 4 || sb_q.size() != 0) begin errors++; $display("FAIL ignore_xfers: got %0d left=%0d, required 4 left=0", xfers - x0, sb_q.size()); end
      idle_cycles(2);
   endtask

   task automatic test_reset_mid_emit();
      int n;
      int x0;
      push_model(8'h7F, 5'd0);
      x0 = xfers;
      do_start(8'h7F, 5'd0);
      n = 0;
      while (!(bus.char_we === 1'b1 && bus.char_addr === 5'd2) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++; if (bus.char_we !== 1'b0) begin errors++; $display("FAIL midreset_we: got %b, required 0", bus.char_we); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b, required 0", o_busy); end
      checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b, required 0", o_done); end
      checks++; if (xfers - x0 !== 2) begin errors++; $display("FAIL midreset_xfers: got %0d, required 2", xfers - x0); end
      sb_q.delete();
      idle_cycles(2);
      test_string(8'h05, 5'd4);
   endtask

   initial begin
      test_reset();
      test_zero();
      test_extremes();
      test_wrap();
      test_stall();
      test_ignore_start();
      test_reset_mid_emit();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
